// File: rtl/scv_pkg.sv
// Shared types for the Super Cassette Vision ROM loader: image indices,
// ROM targets, loader states and the FIFO entry layout.
package scv_pkg;

  localparam logic [7:0] IDX_BOOT = 8'd0;
  localparam logic [7:0] IDX_CHR  = 8'd1;

  typedef enum logic [1:0] {TGT_NONE, TGT_BOOT, TGT_CHR} rom_tgt_t;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_HOLD, ST_RUN} ldr_state_t;

  typedef struct packed {
    rom_tgt_t    tgt;
    logic [11:0] addr;
    logic [7:0]  data;
  } rom_entry_t;

  localparam int ENTRY_W = $bits(rom_entry_t);

  function automatic rom_tgt_t decode_index(input logic [7:0] idx);
    case (idx)
      IDX_BOOT: return TGT_BOOT;
      IDX_CHR:  return TGT_CHR;
      default:  return TGT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/scv_rom_loader_if.sv
// Download stream in, ROM-initialisation write port out.
// The master modport is the framework/core side, slave is the loader.
interface scv_rom_loader_if;
  logic        dl_active;
  logic [7:0]  dl_index;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        dl_wait;
  logic        rominit_sel_boot;
  logic        rominit_sel_chr;
  logic [11:0] rominit_addr;
  logic [7:0]  rominit_data;
  logic        rominit_valid;

  modport master (
    output dl_active, dl_index, dl_addr, dl_data, dl_wr,
    input  dl_wait,
    input  rominit_sel_boot, rominit_sel_chr, rominit_addr, rominit_data, rominit_valid
  );

  modport slave (
    input  dl_active, dl_index, dl_addr, dl_data, dl_wr,
    output dl_wait,
    output rominit_sel_boot, rominit_sel_chr, rominit_addr, rominit_data, rominit_valid
  );
endinterface

// File: rtl/scv_loader_fifo.sv
// Small synchronous FIFO with async reset; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module scv_loader_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/scv_rom_loader.sv
// Converts the byte-serial ROM download into paced ROM-init writes and
// holds the core in reset until a complete boot image is present.
module scv_rom_loader
  import scv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 2,
  parameter int BOOT_SIZE  = 4096,
  parameter int CHR_SIZE   = 1024,
  parameter int RST_HOLD   = 16
) (
  input  logic             clk,
  input  logic             resb,
  scv_rom_loader_if.slave  bus,
  output logic             sys_resb,
  output logic             boot_ok,
  output logic             chr_ok,
  output logic             err_size
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W  = $clog2(WR_GAP + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(WR_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = 1;
  // Two cycles are spent getting from the last strobe into HOLD and out of it,
  // so SYS_RESB rises exactly RST_HOLD cycles after the final VALID.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((RST_HOLD >= 2) ? RST_HOLD - 2 : 0);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = 1;
  localparam logic [12:0]       BOOT_LIM  = 13'(BOOT_SIZE);
  localparam logic [12:0]       CHR_LIM   = 13'(CHR_SIZE);
  localparam logic [CNT_W-1:0]  WAIT_LVL  = CNT_W'(FIFO_DEPTH - 1);

  ldr_state_t        state, state_next;
  rom_tgt_t          tgt, idx_tgt;
  logic              dl_active_q;
  logic [12:0]       byte_cnt;
  logic [12:0]       limit;
  logic              oversize;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              start, in_range, wr_load;
  logic              push, pop, drop_full, drop_over;
  logic              enter_load, drain_done, complete;
  rom_entry_t        in_entry, out_entry;
  logic              fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count, occ_next;

  assign idx_tgt   = decode_index(bus.dl_index);
  assign start     = bus.dl_active & ~dl_active_q & (idx_tgt != TGT_NONE);
  assign limit     = (tgt == TGT_CHR) ? CHR_LIM : BOOT_LIM;
  assign in_range  = bus.dl_addr < {12'd0, limit};
  assign wr_load   = (state == ST_LOAD) & bus.dl_wr;
  assign push      = wr_load & in_range & ~fifo_full;
  assign drop_full = wr_load & in_range & fifo_full;
  assign drop_over = wr_load & ~in_range;
  assign pop       = ~fifo_empty & (gap_cnt == '0);
  assign in_entry  = {tgt, bus.dl_addr[11:0], bus.dl_data};
  assign occ_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);

  scv_loader_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (resb),
    .push  (push),
    .din   (in_entry),
    .pop   (pop),
    .dout  (out_entry),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) state <= ST_HOLD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RUN: if (start) state_next = ST_LOAD;
      ST_LOAD:         if (!bus.dl_active) state_next = ST_DRAIN;
      ST_DRAIN:        if (fifo_empty) state_next = ST_HOLD;
      ST_HOLD: begin
        if (start)                            state_next = ST_LOAD;
        else if ((hold_cnt == '0) && boot_ok) state_next = ST_RUN;
      end
      default:         state_next = ST_HOLD;
    endcase
  end

  always_comb begin
    enter_load = (state_next == ST_LOAD) && (state != ST_LOAD);
    drain_done = (state == ST_DRAIN) && fifo_empty;
    complete   = (byte_cnt == limit) && !oversize;
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      dl_active_q <= 1'b0;
      tgt         <= TGT_NONE;
      byte_cnt    <= '0;
      oversize    <= 1'b0;
      hold_cnt    <= HOLD_LOAD;
      boot_ok     <= 1'b0;
      chr_ok      <= 1'b0;
      err_size    <= 1'b0;
      sys_resb    <= 1'b0;
    end else begin
      dl_active_q <= bus.dl_active;
      sys_resb    <= (state_next == ST_RUN);
      if (enter_load) begin
        tgt      <= idx_tgt;
        byte_cnt <= '0;
        oversize <= 1'b0;
        if (idx_tgt == TGT_BOOT) boot_ok <= 1'b0;
        if (idx_tgt == TGT_CHR)  chr_ok  <= 1'b0;
      end else begin
        if (push && byte_cnt != 13'h1fff) byte_cnt <= byte_cnt + 13'd1;
        if (drop_over) oversize <= 1'b1;
      end
      if (drain_done) begin
        if (tgt == TGT_BOOT) boot_ok <= complete;
        if (tgt == TGT_CHR)  chr_ok  <= complete;
        err_size <= ~complete;
      end else if (drop_full) begin
        err_size <= 1'b1;
      end
      if (state_next == ST_HOLD && state != ST_HOLD) hold_cnt <= HOLD_LOAD;
      else if (state == ST_HOLD && hold_cnt != '0)   hold_cnt <= hold_cnt - HOLD_ONE;
    end
  end

  // Write pacing: a pop reloads the gap so the next pop lands WR_GAP cycles later.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      gap_cnt              <= '0;
      bus.dl_wait          <= 1'b0;
      bus.rominit_valid    <= 1'b0;
      bus.rominit_sel_boot <= 1'b0;
      bus.rominit_sel_chr  <= 1'b0;
      bus.rominit_addr     <= '0;
      bus.rominit_data     <= '0;
    end else begin
      bus.dl_wait       <= (occ_next >= WAIT_LVL);
      bus.rominit_valid <= pop;
      if (pop) begin
        gap_cnt              <= GAP_LOAD;
        bus.rominit_sel_boot <= (out_entry.tgt == TGT_BOOT);
        bus.rominit_sel_chr  <= (out_entry.tgt == TGT_CHR);
        bus.rominit_addr     <= out_entry.addr;
        bus.rominit_data     <= out_entry.data;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_scv_rom_loader.sv
// Directed bench for scv_rom_loader: a table of download scenarios on the
// default instance plus back-pressure and mid-download reset sequences.
module tb_scv_rom_loader;
  import scv_pkg::*;

  logic clk = 1'b0;
  logic resb;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scv_rom_loader_if bus_a ();
  scv_rom_loader_if bus_b ();
  logic sys_resb_a, boot_ok_a, chr_ok_a, err_a;
  logic sys_resb_b, boot_ok_b, chr_ok_b, err_b;

  scv_rom_loader #(.FIFO_DEPTH(4), .WR_GAP(2), .BOOT_SIZE(4096), .CHR_SIZE(1024), .RST_HOLD(16)) dut_a (
    .clk(clk), .resb(resb), .bus(bus_a),
    .sys_resb(sys_resb_a), .boot_ok(boot_ok_a), .chr_ok(chr_ok_a), .err_size(err_a)
  );

  scv_rom_loader #(.FIFO_DEPTH(4), .WR_GAP(4), .BOOT_SIZE(256), .CHR_SIZE(1024), .RST_HOLD(16)) dut_b (
    .clk(clk), .resb(resb), .bus(bus_b),
    .sys_resb(sys_resb_b), .boot_ok(boot_ok_b), .chr_ok(chr_ok_b), .err_size(err_b)
  );

  typedef struct {
    logic [7:0] idx;
    int         n;
    bit         drop_last;
    int         exp_valids;
    bit         exp_boot, exp_chr, exp_err, exp_resb;
    bit         exp_resb_at_start, exp_low_seen, exp_wait_seen;
  } row_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(input bit chr, input int a);
    logic [31:0] av;
    av = a;
    return chr ? (av[7:0] ^ 8'hA5) : av[7:0];
  endfunction

  int a_vcnt = 0, a_next = 0, a_first_v = 0, a_last_v = 0, a_rise = 0;
  bit a_exp_chr = 1'b0, a_low_seen = 1'b0, a_wait_seen = 1'b0;
  logic a_resb_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus_a.rominit_valid === 1'b1) begin
      if (a_vcnt == 0) a_first_v = cyc;
      a_last_v = cyc;
      chk("a_word", {bus_a.rominit_sel_boot, bus_a.rominit_sel_chr, bus_a.rominit_addr, bus_a.rominit_data},
          {~a_exp_chr, a_exp_chr, 12'(a_next), pat(a_exp_chr, a_next)});
      a_vcnt++;
      a_next++;
    end
    if (sys_resb_a === 1'b1 && a_resb_prev !== 1'b1) a_rise = cyc;
    if (sys_resb_a !== 1'b1) a_low_seen = 1'b1;
    if (bus_a.dl_wait === 1'b1) a_wait_seen = 1'b1;
    a_resb_prev = sys_resb_a;
  end

  int b_vcnt = 0, b_prev_v = 0, b_wait_rise = 0, b_wait_fall = 0;
  logic b_wait_prev = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus_b.rominit_valid === 1'b1) begin
      if (b_vcnt > 0) chk("b_spacing", 64'(cyc - b_prev_v), 64'd4);
      chk("b_word", {bus_b.rominit_sel_boot, bus_b.rominit_sel_chr, bus_b.rominit_addr, bus_b.rominit_data},
          {1'b1, 1'b0, 12'(b_vcnt), pat(1'b0, b_vcnt)});
      b_prev_v = cyc;
      b_vcnt++;
    end
    if (bus_b.dl_wait === 1'b1 && b_wait_prev === 1'b0) b_wait_rise++;
    if (bus_b.dl_wait === 1'b0 && b_wait_prev === 1'b1) b_wait_fall++;
    b_wait_prev = bus_b.dl_wait;
  end

  task automatic run_a(input logic [7:0] idx, input int n, input bit drop_last, input int abort_at,
                       output int first_wr, output logic resb_at_start);
    int i, guard;
    bit chr;
    chr = (idx == IDX_CHR);
    @(posedge clk); #1;
    bus_a.dl_index  = idx;
    bus_a.dl_active = 1'b1;
    @(posedge clk); #1;
    resb_at_start = sys_resb_a;
    first_wr = -1;
    i = 0;
    guard = 0;
    while (i < n && guard < 4 * n + 100) begin
      if (abort_at >= 0 && i == abort_at) begin
        resb = 1'b0;
        break;
      end
      if (bus_a.dl_wait === 1'b0) begin
        bus_a.dl_wr   = 1'b1;
        bus_a.dl_addr = 25'(i);
        bus_a.dl_data = pat(chr, i);
        if (i == 0) first_wr = cyc;
        if (drop_last && i == n - 1) bus_a.dl_active = 1'b0;
        i++;
      end else begin
        bus_a.dl_wr = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    chk("producer_progress", 64'(i), 64'((abort_at >= 0) ? abort_at : n));
    bus_a.dl_wr     = 1'b0;
    bus_a.dl_active = 1'b0;
  endtask

  task automatic check_row(input row_t r, input string tag);
    int   fw;
    logic ras;
    a_vcnt      = 0;
    a_next      = 0;
    a_exp_chr   = (r.idx == IDX_CHR);
    a_low_seen  = 1'b0;
    a_wait_seen = 1'b0;
    run_a(r.idx, r.n, r.drop_last, -1, fw, ras);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk({tag, "_valids"}, 64'(a_vcnt), 64'(r.exp_valids));
    chk({tag, "_boot_ok"}, 64'(boot_ok_a), 64'(r.exp_boot));
    chk({tag, "_chr_ok"}, 64'(chr_ok_a), 64'(r.exp_chr));
    chk({tag, "_err_size"}, 64'(err_a), 64'(r.exp_err));
    chk({tag, "_sys_resb"}, 64'(sys_resb_a), 64'(r.exp_resb));
    chk({tag, "_resb_at_start"}, 64'(ras), 64'(r.exp_resb_at_start));
    chk({tag, "_resb_low_seen"}, 64'(a_low_seen), 64'(r.exp_low_seen));
    chk({tag, "_wait_seen"}, 64'(a_wait_seen), 64'(r.exp_wait_seen));
    if (r.exp_valids > 0) chk({tag, "_latency"}, 64'(a_first_v - fw), 64'd2);
    if (r.exp_resb && r.exp_low_seen) chk({tag, "_hold_len"}, 64'(a_rise - a_last_v), 64'd16);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_a_outs"}, {bus_a.dl_wait, bus_a.rominit_sel_boot, bus_a.rominit_sel_chr, bus_a.rominit_addr,
        bus_a.rominit_data, bus_a.rominit_valid, sys_resb_a, boot_ok_a, chr_ok_a, err_a}, 64'd0);
    chk({tag, "_b_outs"}, {bus_b.dl_wait, bus_b.rominit_sel_boot, bus_b.rominit_sel_chr, bus_b.rominit_addr,
        bus_b.rominit_data, bus_b.rominit_valid, sys_resb_b, boot_ok_b, chr_ok_b, err_b}, 64'd0);
  endtask

  row_t tbl[6];

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fw, vc, i, guard;
    logic ras;

    //            idx  n     drop  valids boot chr err resb start low wait
    tbl[0] = '{8'd0, 4096, 1'b0, 4096, 1, 0, 0, 1, 0, 1, 1};
    tbl[1] = '{8'd1, 1024, 1'b1, 1024, 1, 1, 0, 1, 0, 1, 1};
    tbl[2] = '{8'd5, 300,  1'b0, 0,    1, 1, 0, 1, 1, 0, 0};
    tbl[3] = '{8'd0, 100,  1'b0, 100,  0, 1, 1, 0, 0, 1, 1};
    tbl[4] = '{8'd0, 5000, 1'b0, 4096, 0, 1, 1, 0, 0, 1, 1};
    tbl[5] = '{8'd0, 4096, 1'b0, 4096, 1, 0, 0, 1, 0, 1, 1};

    resb = 1'b0;
    bus_a.dl_active = 1'b0; bus_a.dl_index = 8'd0; bus_a.dl_addr = '0; bus_a.dl_data = '0; bus_a.dl_wr = 1'b0;
    bus_b.dl_active = 1'b0; bus_b.dl_index = 8'd0; bus_b.dl_addr = '0; bus_b.dl_data = '0; bus_b.dl_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("in_reset");
    @(posedge clk); #1;
    resb = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_vals("after_reset");

    // Back-pressure on the WR_GAP=4 instance with a 256-byte boot image.
    @(posedge clk); #1;
    bus_b.dl_active = 1'b1;
    @(posedge clk); #1;
    i = 0;
    guard = 0;
    while (i < 256 && guard < 2000) begin
      if (bus_b.dl_wait === 1'b0) begin
        bus_b.dl_wr   = 1'b1;
        bus_b.dl_addr = 25'(i);
        bus_b.dl_data = pat(1'b0, i);
        i++;
      end else begin
        bus_b.dl_wr = 1'b0;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus_b.dl_wr     = 1'b0;
    bus_b.dl_active = 1'b0;
    repeat (60) @(negedge clk);
    chk("bp_producer_progress", 64'(i), 64'd256);
    chk("bp_valids", 64'(b_vcnt), 64'd256);
    chk("bp_err_size", 64'(err_b), 64'd0);
    chk("bp_boot_ok", 64'(boot_ok_b), 64'd1);
    chk("bp_sys_resb", 64'(sys_resb_b), 64'd1);
    chk("bp_wait_rose", 64'(b_wait_rise > 0), 64'd1);
    chk("bp_wait_fell", 64'(b_wait_fall > 0), 64'd1);

    for (int r = 0; r < 5; r++) check_row(tbl[r], $sformatf("row%0d", r));

    // Reset in the middle of a boot download, then a clean reload.
    a_vcnt = 0;
    a_next = 0;
    a_exp_chr = 1'b0;
    run_a(IDX_BOOT, 4096, 1'b0, 2000, fw, ras);
    #2;
    check_reset_vals("mid_reset");
    vc = a_vcnt;
    repeat (5) @(posedge clk);
    #1;
    resb = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_reset_no_valid", 64'(a_vcnt), 64'(vc));
    chk("mid_reset_sys_resb", 64'(sys_resb_a), 64'd0);
    chk("mid_reset_dl_wait", 64'(bus_a.dl_wait), 64'd0);
    check_row(tbl[5], "reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
